// File: rtl/contador_param_if.sv
// Bus bundle for contador_param: control/data inputs and registered results.
// The driver side (bench or parent logic) takes the master modport; the
// counter itself takes the slave modport.
interface contador_param_if #(
  parameter int WIDTH = 4
) ();

  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] count;
  logic             rco;
  logic             load;

  modport master (
    output enable,
    output mode,
    output D,
    input  count,
    input  rco,
    input  load
  );

  modport slave (
    input  enable,
    input  mode,
    input  D,
    output count,
    output rco,
    output load
  );

endinterface

// File: rtl/contador_param.sv
// Parametrised multi-mode counter: up by 1, down by 1, up by 3, parallel load.
// Overflow/underflow either wraps modulo 2^WIDTH or clamps at the range ends,
// chosen by SATURATE. count, rco and load are all registered; the only
// non-clocked path is the asynchronous active-low reset.
module contador_param #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  contador_param_if.slave bus
);

  // Two guard bits: the top one flags a negative result, the next one flags
  // a result that went past 2^WIDTH-1 (worst case is max+3, which fits).
  localparam int EW = WIDTH + 2;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_UP3  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  mode_e            mode_s;
  logic [WIDTH-1:0] count_q, count_d;
  logic             rco_q, rco_d;
  logic             load_q, load_d;
  logic [EW-1:0]    cur_ext;
  logic [EW-1:0]    exact;
  logic             over;
  logic             under;
  logic [WIDTH-1:0] oor_value;

  assign mode_s  = mode_e'(bus.mode);
  assign cur_ext = {2'b00, count_q};

  // Exact (unwrapped) result of the selected arithmetic mode.
  always_comb begin
    exact = cur_ext;
    case (mode_s)
      MODE_UP:   exact = cur_ext + EW'(1);
      MODE_DOWN: exact = cur_ext - EW'(1);
      MODE_UP3:  exact = cur_ext + EW'(3);
      default:   exact = cur_ext;
    endcase
  end

  // Sign bit set means below zero; otherwise bit WIDTH set means above max.
  assign under = exact[EW-1];
  assign over  = ~exact[EW-1] & exact[WIDTH];

  // Value taken when the exact result is out of range.
  generate
    if (SATURATE) begin : g_sat
      assign oor_value = over ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    end else begin : g_wrap
      assign oor_value = exact[WIDTH-1:0];
    end
  endgenerate

  // Next-state selection: hold, load, in-range update or out-of-range policy.
  always_comb begin
    count_d = count_q;
    rco_d   = 1'b0;
    load_d  = 1'b0;
    if (bus.enable) begin
      if (mode_s == MODE_LOAD) begin
        count_d = bus.D;
        load_d  = 1'b1;
      end else if (over || under) begin
        count_d = oor_value;
        rco_d   = 1'b1;
      end else begin
        count_d = exact[WIDTH-1:0];
      end
    end
  end

  // State registers; reset clears everything immediately, no pending work kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      rco_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      rco_q   <= rco_d;
      load_q  <= load_d;
    end
  end

  assign bus.count = count_q;
  assign bus.rco   = rco_q;
  assign bus.load  = load_q;

endmodule

// File: tb/tb_contador_param.sv
// Bench for contador_param: three instances (4-bit wrap, 4-bit saturate,
// 8-bit wrap), directed scenarios plus randomized traffic checked against an
// integer-arithmetic reference model.
module tb_contador_param;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  contador_param_if #(.WIDTH(4)) a_if ();
  contador_param_if #(.WIDTH(4)) b_if ();
  contador_param_if #(.WIDTH(8)) c_if ();

  contador_param #(.WIDTH(4), .SATURATE(1'b0)) u_a (.clk(clk), .reset(reset), .bus(a_if.slave));
  contador_param #(.WIDTH(4), .SATURATE(1'b1)) u_b (.clk(clk), .reset(reset), .bus(b_if.slave));
  contador_param #(.WIDTH(8), .SATURATE(1'b0)) u_c (.clk(clk), .reset(reset), .bus(c_if.slave));

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic       en;
    logic [1:0] m;
    logic [7:0] d;
    logic [7:0] cnt;
    logic       rco;
    logic       ld;
  } step_t;

  // Reference: exact integer result, then wrap or clamp when out of range.
  task automatic ref_step(input int width, input bit sat, input bit en, input logic [1:0] m,
                          input int d, input int cur, output int nxt, output bit rco, output bit ld);
    int maxv;
    int exact;
    maxv = (1 << width) - 1;
    nxt  = cur;
    rco  = 1'b0;
    ld   = 1'b0;
    if (!en) return;
    if (m == 2'b11) begin
      nxt = d;
      ld  = 1'b1;
      return;
    end
    exact = cur + ((m == 2'b00) ? 1 : (m == 2'b01) ? -1 : 3);
    if (exact > maxv) begin
      rco = 1'b1;
      nxt = sat ? maxv : exact - (maxv + 1);
    end else if (exact < 0) begin
      rco = 1'b1;
      nxt = sat ? 0 : exact + (maxv + 1);
    end else begin
      nxt = exact;
    end
  endtask

  task automatic idle_all();
    a_if.enable = 1'b0; a_if.mode = 2'b00; a_if.D = '0;
    b_if.enable = 1'b0; b_if.mode = 2'b00; b_if.D = '0;
    c_if.enable = 1'b0; c_if.mode = 2'b00; c_if.D = '0;
  endtask

  task automatic drive_a(input bit en, input logic [1:0] m, input logic [3:0] d);
    a_if.enable = en; a_if.mode = m; a_if.D = d;
    @(posedge clk); #1;
  endtask

  task automatic drive_b(input bit en, input logic [1:0] m, input logic [3:0] d);
    b_if.enable = en; b_if.mode = m; b_if.D = d;
    @(posedge clk); #1;
  endtask

  task automatic drive_c(input bit en, input logic [1:0] m, input logic [7:0] d);
    c_if.enable = en; c_if.mode = m; c_if.D = d;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1'b0;
    #2;
    compared++;
    if ({a_if.count, a_if.rco, a_if.load} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_a: got count=%0d rco=%0b load=%0b, expected all 0", a_if.count, a_if.rco, a_if.load);
    end
    compared++;
    if ({b_if.count, b_if.rco, b_if.load} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_b: got count=%0d rco=%0b load=%0b, expected all 0", b_if.count, b_if.rco, b_if.load);
    end
    compared++;
    if ({c_if.count, c_if.rco, c_if.load} !== 10'b0) begin
      mismatched++;
      $display("FAIL reset_c: got count=%0d rco=%0b load=%0b, expected all 0", c_if.count, c_if.rco, c_if.load);
    end
    @(negedge clk) reset = 1'b1;
    drive_a(1'b1, 2'b11, 4'd8);
    drive_a(1'b1, 2'b00, 4'd0);
    compared++;
    if (a_if.count !== 4'd9) begin
      mismatched++;
      $display("FAIL reset_run9: got count=%0d, expected 9", a_if.count);
    end
    // assert reset mid-cycle and look before the next edge
    #2 reset = 1'b0;
    #1;
    compared++;
    if ({a_if.count, a_if.rco, a_if.load} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_async: got count=%0d rco=%0b load=%0b, expected all 0", a_if.count, a_if.rco, a_if.load);
    end
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b0, 2'b00, 4'd5);
      compared++;
      if ({a_if.count, a_if.rco, a_if.load} !== 6'b0) begin
        mismatched++;
        $display("FAIL reset_hold[%0d]: got count=%0d rco=%0b load=%0b, expected all 0", i, a_if.count, a_if.rco, a_if.load);
      end
    end
  endtask

  task automatic test_up_wrap();
    int exp_cnt;
    bit exp_rco;
    idle_all();
    drive_a(1'b1, 2'b11, 4'd0);
    for (int i = 0; i < 17; i++) begin
      drive_a(1'b1, 2'b00, 4'd0);
      exp_cnt = (i + 1) % 16;
      exp_rco = ((i + 1) == 16);
      compared++;
      if (a_if.count !== 4'(exp_cnt) || a_if.rco !== exp_rco || a_if.load !== 1'b0) begin
        mismatched++;
        $display("FAIL up_wrap[%0d]: got count=%0d rco=%0b load=%0b, expected count=%0d rco=%0b load=0",
                 i, a_if.count, a_if.rco, a_if.load, exp_cnt, exp_rco);
      end
    end
  endtask

  task automatic test_down_up3();
    step_t seq [8];
    seq = '{'{1'b1, 2'b11, 8'd2,  8'd2,  1'b0, 1'b1},
            '{1'b1, 2'b01, 8'd0,  8'd1,  1'b0, 1'b0},
            '{1'b1, 2'b01, 8'd0,  8'd0,  1'b0, 1'b0},
            '{1'b1, 2'b01, 8'd0,  8'd15, 1'b1, 1'b0},
            '{1'b1, 2'b11, 8'd13, 8'd13, 1'b0, 1'b1},
            '{1'b1, 2'b10, 8'd0,  8'd0,  1'b1, 1'b0},
            '{1'b1, 2'b10, 8'd0,  8'd3,  1'b0, 1'b0},
            '{1'b1, 2'b10, 8'd0,  8'd6,  1'b0, 1'b0}};
    idle_all();
    for (int i = 0; i < 8; i++) begin
      drive_a(seq[i].en, seq[i].m, seq[i].d[3:0]);
      compared++;
      if (a_if.count !== seq[i].cnt[3:0] || a_if.rco !== seq[i].rco || a_if.load !== seq[i].ld) begin
        mismatched++;
        $display("FAIL down_up3[%0d]: got count=%0d rco=%0b load=%0b, expected count=%0d rco=%0b load=%0b",
                 i, a_if.count, a_if.rco, a_if.load, seq[i].cnt, seq[i].rco, seq[i].ld);
      end
    end
  endtask

  task automatic test_load();
    step_t seq [4];
    seq = '{'{1'b1, 2'b11, 8'hA, 8'd10, 1'b0, 1'b1},
            '{1'b0, 2'b11, 8'h3, 8'd10, 1'b0, 1'b0},
            '{1'b1, 2'b11, 8'hF, 8'd15, 1'b0, 1'b1},
            '{1'b1, 2'b11, 8'hF, 8'd15, 1'b0, 1'b1}};
    idle_all();
    for (int i = 0; i < 4; i++) begin
      drive_a(seq[i].en, seq[i].m, seq[i].d[3:0]);
      compared++;
      if (a_if.count !== seq[i].cnt[3:0] || a_if.rco !== seq[i].rco || a_if.load !== seq[i].ld) begin
        mismatched++;
        $display("FAIL load[%0d]: got count=%0d rco=%0b load=%0b, expected count=%0d rco=%0b load=%0b",
                 i, a_if.count, a_if.rco, a_if.load, seq[i].cnt, seq[i].rco, seq[i].ld);
      end
    end
  endtask

  task automatic test_saturate();
    step_t seq [8];
    seq = '{'{1'b1, 2'b11, 8'd14, 8'd14, 1'b0, 1'b1},
            '{1'b1, 2'b10, 8'd0,  8'd15, 1'b1, 1'b0},
            '{1'b1, 2'b10, 8'd0,  8'd15, 1'b1, 1'b0},
            '{1'b1, 2'b00, 8'd0,  8'd15, 1'b1, 1'b0},
            '{1'b1, 2'b11, 8'd1,  8'd1,  1'b0, 1'b1},
            '{1'b1, 2'b01, 8'd0,  8'd0,  1'b0, 1'b0},
            '{1'b1, 2'b01, 8'd0,  8'd0,  1'b1, 1'b0},
            '{1'b0, 2'b01, 8'd0,  8'd0,  1'b0, 1'b0}};
    idle_all();
    for (int i = 0; i < 8; i++) begin
      drive_b(seq[i].en, seq[i].m, seq[i].d[3:0]);
      compared++;
      if (b_if.count !== seq[i].cnt[3:0] || b_if.rco !== seq[i].rco || b_if.load !== seq[i].ld) begin
        mismatched++;
        $display("FAIL saturate[%0d]: got count=%0d rco=%0b load=%0b, expected count=%0d rco=%0b load=%0b",
                 i, b_if.count, b_if.rco, b_if.load, seq[i].cnt, seq[i].rco, seq[i].ld);
      end
    end
  endtask

  task automatic test_width8();
    step_t seq [5];
    seq = '{'{1'b1, 2'b11, 8'hFE, 8'hFE, 1'b0, 1'b1},
            '{1'b1, 2'b00, 8'h00, 8'hFF, 1'b0, 1'b0},
            '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0},
            '{1'b1, 2'b00, 8'h00, 8'h01, 1'b0, 1'b0},
            '{1'b1, 2'b11, 8'h80, 8'h80, 1'b0, 1'b1}};
    idle_all();
    for (int i = 0; i < 5; i++) begin
      drive_c(seq[i].en, seq[i].m, seq[i].d);
      compared++;
      if (c_if.count !== seq[i].cnt || c_if.rco !== seq[i].rco || c_if.load !== seq[i].ld) begin
        mismatched++;
        $display("FAIL width8[%0d]: got count=%0h rco=%0b load=%0b, expected count=%0h rco=%0b load=%0b",
                 i, c_if.count, c_if.rco, c_if.load, seq[i].cnt, seq[i].rco, seq[i].ld);
      end
    end
    // load pulse is active now; reset mid-cycle must clear it at once
    #2 reset = 1'b0;
    #1;
    compared++;
    if ({c_if.count, c_if.rco, c_if.load} !== 10'b0) begin
      mismatched++;
      $display("FAIL width8_reset: got count=%0h rco=%0b load=%0b, expected all 0", c_if.count, c_if.rco, c_if.load);
    end
    @(negedge clk) reset = 1'b1;
    drive_c(1'b1, 2'b01, 8'h00);
    compared++;
    if (c_if.count !== 8'hFF || c_if.rco !== 1'b1) begin
      mismatched++;
      $display("FAIL width8_after_reset: got count=%0h rco=%0b, expected count=ff rco=1", c_if.count, c_if.rco);
    end
  endtask

  task automatic test_random();
    int ma, mb, mc;
    int na, nb, nc;
    bit ra, rb, rc, la, lb, lc;
    ma = a_if.count; mb = b_if.count; mc = c_if.count;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 49) == 0) begin
        // occasional asynchronous reset pulse in the middle of a cycle
        #2 reset = 1'b0;
        #1;
        ma = 0; mb = 0; mc = 0;
        compared++;
        if (a_if.count !== 4'd0 || b_if.count !== 4'd0 || c_if.count !== 8'd0) begin
          mismatched++;
          $display("FAIL rand_reset cycle %0d: got counts %0d %0d %0h, expected 0 0 0",
                   cyc, a_if.count, b_if.count, c_if.count);
        end
        @(negedge clk) reset = 1'b1;
      end
      a_if.enable = ($urandom_range(0, 3) != 0); a_if.mode = 2'($urandom); a_if.D = 4'($urandom);
      b_if.enable = ($urandom_range(0, 3) != 0); b_if.mode = 2'($urandom); b_if.D = 4'($urandom);
      c_if.enable = ($urandom_range(0, 3) != 0); c_if.mode = 2'($urandom); c_if.D = 8'($urandom);
      ref_step(4, 1'b0, a_if.enable, a_if.mode, int'(a_if.D), ma, na, ra, la);
      ref_step(4, 1'b1, b_if.enable, b_if.mode, int'(b_if.D), mb, nb, rb, lb);
      ref_step(8, 1'b0, c_if.enable, c_if.mode, int'(c_if.D), mc, nc, rc, lc);
      ma = na; mb = nb; mc = nc;
      @(posedge clk); #1;
      compared++;
      if (a_if.count !== 4'(ma) || a_if.rco !== ra || a_if.load !== la) begin
        mismatched++;
        $display("FAIL rand_a cycle %0d: got count=%0d rco=%0b load=%0b, expected count=%0d rco=%0b load=%0b",
                 cyc, a_if.count, a_if.rco, a_if.load, ma, ra, la);
      end
      compared++;
      if (b_if.count !== 4'(mb) || b_if.rco !== rb || b_if.load !== lb) begin
        mismatched++;
        $display("FAIL rand_b cycle %0d: got count=%0d rco=%0b load=%0b, expected count=%0d rco=%0b load=%0b",
                 cyc, b_if.count, b_if.rco, b_if.load, mb, rb, lb);
      end
      compared++;
      if (c_if.count !== 8'(mc) || c_if.rco !== rc || c_if.load !== lc) begin
        mismatched++;
        $display("FAIL rand_c cycle %0d: got count=%0h rco=%0b load=%0b, expected count=%0h rco=%0b load=%0b",
                 cyc, c_if.count, c_if.rco, c_if.load, mc, rc, lc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_up3();
    test_load();
    test_saturate();
    test_width8();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
